// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, counter debounce, and a hold
// state machine producing press/release/long-press/auto-repeat pulses.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 540000,
  parameter int LONG_CYCLES     = 27000000,
  parameter int REPEAT_CYCLES   = 5400000
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic iKEYn,
  output logic oLEVEL,
  output logic oPRESS,
  output logic oRELEASE,
  output logic oLONG,
  output logic oREPEAT
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int HW = (LW > RW) ? LW : RW;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_HELD     = 2'd1,
    ST_LONGHELD = 2'd2
  } hold_state_e;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [DW-1:0] r_db_cnt;
  logic [HW-1:0] r_hold_cnt;
  hold_state_e   r_state;
  logic          r_press;
  logic          r_release;
  logic          r_long;
  logic          r_repeat;

  logic          w_raw_pressed;
  logic          w_differs;
  logic          w_accept;
  logic          w_acc_press;
  logic          w_acc_release;
  logic          w_long_hit;
  logic          w_rep_hit;
  hold_state_e   w_state_next;
  logic [HW-1:0] w_hold_next;

  // Synchronizer idles at 1 so reset looks like a released key.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= iKEYn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw_pressed = ~r_sync2;
  assign w_differs     = (w_raw_pressed != r_level);
  assign w_accept      = w_differs && (r_db_cnt == DEB_LAST);
  assign w_acc_press   = w_accept && !r_level;
  assign w_acc_release = w_accept && r_level;

  // Any sample matching the stable level restarts the count, so glitches leave no residue.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_level  <= 1'b0;
      r_db_cnt <= '0;
    end else if (!w_differs) begin
      r_db_cnt <= '0;
    end else if (w_accept) begin
      r_level  <= ~r_level;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // Thresholds are masked by a simultaneous release so the release wins.
  assign w_long_hit = (r_state == ST_HELD) && (r_hold_cnt == LONG_LAST) && !w_acc_release;
  assign w_rep_hit  = (r_state == ST_LONGHELD) && (r_hold_cnt == REP_LAST) && !w_acc_release;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state    <= ST_RELEASED;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_acc_release) begin
      w_state_next = ST_RELEASED;
    end else if (w_acc_press) begin
      w_state_next = ST_HELD;
    end else if (w_long_hit) begin
      w_state_next = ST_LONGHELD;
    end
  end

  always_comb begin
    w_hold_next = r_hold_cnt;
    if (w_acc_press || w_acc_release || w_long_hit || w_rep_hit) begin
      w_hold_next = '0;
    end else if (r_state != ST_RELEASED) begin
      w_hold_next = r_hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_press   <= w_acc_press;
      r_release <= w_acc_release;
      r_long    <= w_long_hit;
      r_repeat  <= w_rep_hit;
    end
  end

  assign oLEVEL   = r_level;
  assign oPRESS   = r_press;
  assign oRELEASE = r_release;
  assign oLONG    = r_long;
  assign oREPEAT  = r_repeat;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: scenario vectors built into a table, expected outputs
// queued as each vector is driven and popped once the clock edge has produced them.
module tb_key_debounce;

  localparam int DEB  = 4;
  localparam int LNG  = 20;
  localparam int REP  = 8;
  localparam int MAXV = 512;

  // Expected output word: {level, press, release, long, repeat}
  localparam logic [4:0] P_PRESS = 5'b01000;
  localparam logic [4:0] P_REL   = 5'b00100;
  localparam logic [4:0] P_LONG  = 5'b00010;
  localparam logic [4:0] P_REP   = 5'b00001;

  typedef struct {
    logic       rst_n;
    logic       key_n;
    logic [4:0] exp;
    string      tag;
  } vec_t;

  logic CLK = 1'b0;
  logic RESETn;
  logic iKEYn;
  logic oLEVEL, oPRESS, oRELEASE, oLONG, oREPEAT;

  vec_t       vecs [MAXV];
  int         n_vec = 0;
  int         n_applied = 0;
  int         n_miscompares = 0;
  logic [4:0] exp_q [$];

  key_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LNG),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .iKEYn   (iKEYn),
    .oLEVEL  (oLEVEL),
    .oPRESS  (oPRESS),
    .oRELEASE(oRELEASE),
    .oLONG   (oLONG),
    .oREPEAT (oREPEAT)
  );

  always #5 CLK = ~CLK;

  task automatic seg(input logic rst_n, input logic key_n, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      if (n_vec >= MAXV) begin
        $display("FAIL table_overflow: got %0d entries, limit %0d", n_vec, MAXV);
        $fatal(1);
      end
      vecs[n_vec].rst_n = rst_n;
      vecs[n_vec].key_n = key_n;
      vecs[n_vec].exp   = 5'b0;
      vecs[n_vec].tag   = tag;
      n_vec++;
    end
  endtask

  task automatic hi(input int a, input int b);
    for (int i = a; i < b; i++) vecs[i].exp[4] = 1'b1;
  endtask

  task automatic pulse(input int idx, input logic [4:0] p);
    vecs[idx].exp = vecs[idx].exp | p;
  endtask

  task automatic cmp(input string name, input int idx, input logic [4:0] want);
    logic [4:0] got;
    got = {oLEVEL, oPRESS, oRELEASE, oLONG, oREPEAT};
    n_applied++;
    if (got !== want) begin
      n_miscompares++;
      $display("FAIL %s[%0d]: got {lvl,prs,rel,lng,rep}=%b expected %b", name, idx, got, want);
    end
  endtask

  initial begin
    int p, r, q, s;
    RESETn = 1'b0;
    iKEYn  = 1'b1;

    // Reset state
    seg(1'b0, 1'b1, 3, "reset");

    // Clean press then release
    seg(1'b1, 1'b1, 5, "idle");
    p = n_vec; seg(1'b1, 1'b0, 12, "clean_press");
    r = n_vec; seg(1'b1, 1'b1, 10, "clean_release");
    hi(p + 5, r + 5); pulse(p + 5, P_PRESS); pulse(r + 5, P_REL);

    // Glitch of 3 low cycles
    seg(1'b1, 1'b0, 3, "glitch");
    seg(1'b1, 1'b1, 22, "glitch_after");

    // Long press with repeats, released before the fourth repeat
    p = n_vec; seg(1'b1, 1'b0, 50, "long_hold");
    r = n_vec; seg(1'b1, 1'b1, 10, "long_release");
    hi(p + 5, r + 5);
    pulse(p + 5, P_PRESS); pulse(p + 25, P_LONG);
    pulse(p + 33, P_REP); pulse(p + 41, P_REP); pulse(p + 49, P_REP);
    pulse(r + 5, P_REL);

    // Accepted release lands on the long threshold
    p = n_vec; seg(1'b1, 1'b0, 20, "rel_on_long");
    r = n_vec; seg(1'b1, 1'b1, 15, "rel_on_long_after");
    hi(p + 5, r + 5); pulse(p + 5, P_PRESS); pulse(r + 5, P_REL);

    // Reset mid-hold, key still pressed afterwards
    p = n_vec; seg(1'b1, 1'b0, 15, "pre_reset_hold");
    seg(1'b0, 1'b0, 2, "reset_mid_hold");
    q = n_vec; seg(1'b1, 1'b0, 12, "post_reset_press");
    r = n_vec; seg(1'b1, 1'b1, 10, "post_reset_release");
    hi(p + 5, p + 15); pulse(p + 5, P_PRESS);
    hi(q + 5, r + 5); pulse(q + 5, P_PRESS); pulse(r + 5, P_REL);

    // Bounce train: 2-cycle runs for 30 cycles, last run stays low
    for (int k = 0; k < 15; k++) seg(1'b1, (k % 2 == 0) ? 1'b0 : 1'b1, 2, "bounce");
    s = n_vec - 2;
    seg(1'b1, 1'b0, 15, "bounce_settled");
    r = n_vec; seg(1'b1, 1'b1, 10, "bounce_release");
    hi(s + 5, r + 5); pulse(s + 5, P_PRESS); pulse(r + 5, P_REL);

    // Reset mid-debounce aborts without a pulse
    seg(1'b1, 1'b0, 3, "pre_reset_debounce");
    seg(1'b0, 1'b0, 1, "reset_mid_debounce");
    seg(1'b1, 1'b1, 10, "post_reset_idle");

    for (int i = 0; i < n_vec; i++) begin
      @(negedge CLK);
      RESETn = vecs[i].rst_n;
      iKEYn  = vecs[i].key_n;
      exp_q.push_back(vecs[i].exp);
      if (!vecs[i].rst_n) begin
        #1;
        cmp({vecs[i].tag, "_async"}, i, 5'b0);
      end
      @(posedge CLK);
      #1;
      if (exp_q.size() == 0) begin
        n_applied++;
        n_miscompares++;
        $display("FAIL scoreboard_empty[%0d]: got empty queue, required one entry", i);
      end else begin
        cmp(vecs[i].tag, i, exp_q.pop_front());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
